// File: rtl/algo_1r6w_a664_pkg.sv
// Shared sizes and write-beat payload for the 1r6w a664 write-ingress stage.
package algo_1r6w_a664_pkg;

    // Ceiling log2, used to size FIFO pointers from the depth.
    function automatic int unsigned log2_ceil(input int unsigned v);
        int unsigned r;
        r = 0;
        while ((32'd1 << r) < v) begin
            r = r + 1;
        end
        return r;
    endfunction

    localparam int unsigned NUMWRPT = 6;
    localparam int unsigned WIDTH   = 32;
    localparam int unsigned BITADDR = 13;
    localparam int unsigned FIFODEP = 4;
    localparam int unsigned BITFIFO = log2_ceil(FIFODEP);
    localparam int unsigned BITCNT  = BITFIFO + 1;

    // One buffered client write.
    typedef struct packed {
        logic [BITADDR-1:0] adr;
        logic [WIDTH-1:0]   din;
    } wr_beat_t;

endpackage

// File: rtl/algo_wr_fifo.sv
// Single-clock per-port write FIFO; head is the oldest beat, visible the cycle after push.
module algo_wr_fifo
    import algo_1r6w_a664_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic              pop,
    input  wr_beat_t          wdata,
    output wr_beat_t          head,
    output logic [BITCNT-1:0] cnt,
    output logic              full,
    output logic              empty
);

    wr_beat_t           mem [FIFODEP];
    logic [BITFIFO-1:0] wptr;
    logic [BITFIFO-1:0] rptr;
    logic               do_push;
    logic               do_pop;

    assign full    = (cnt == BITCNT'(FIFODEP));
    assign empty   = (cnt == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign head    = mem[rptr];

    // Storage array; contents are don't-care after reset.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wptr] <= wdata;
        end
    end

    // Pointers and occupancy; pointers wrap naturally.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wptr <= '0;
            rptr <= '0;
            cnt  <= '0;
        end else begin
            if (do_push) begin
                wptr <= wptr + BITFIFO'(1);
            end
            if (do_pop) begin
                rptr <= rptr + BITFIFO'(1);
            end
            if (do_push && !do_pop) begin
                cnt <= cnt + BITCNT'(1);
            end else if (do_pop && !do_push) begin
                cnt <= cnt - BITCNT'(1);
            end
        end
    end

endmodule

// File: rtl/algo_1r6w_a664_wr_stage.sv
// Write-ingress stage: buffers six client write streams and issues them to the
// 1r6w macro, serialising same-cycle writes that target the same address.
module algo_1r6w_a664_wr_stage
    import algo_1r6w_a664_pkg::*;
(
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUMWRPT-1:0]          cl_vld,
    output logic [NUMWRPT-1:0]          cl_rdy,
    input  logic [NUMWRPT*BITADDR-1:0]  cl_adr,
    input  logic [NUMWRPT*WIDTH-1:0]    cl_din,
    input  logic                        ready,
    input  logic                        wr_bp,
    output logic [NUMWRPT-1:0]          write,
    output logic [NUMWRPT*BITADDR-1:0]  wr_adr,
    output logic [NUMWRPT*WIDTH-1:0]    din,
    output logic [NUMWRPT*BITCNT-1:0]   fifo_cnt,
    output logic                        idle
);

    logic               run;
    logic [NUMWRPT-1:0] push;
    logic [NUMWRPT-1:0] full;
    logic [NUMWRPT-1:0] empty;
    logic [NUMWRPT-1:0] elig;
    logic [NUMWRPT-1:0] issue;
    wr_beat_t           in_beat [NUMWRPT];
    wr_beat_t           head    [NUMWRPT];
    logic [BITCNT-1:0]  cnt     [NUMWRPT];

    // Holds client accept low until the first clock after reset release.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            run <= 1'b0;
        end else begin
            run <= 1'b1;
        end
    end

    assign cl_rdy = {NUMWRPT{run}} & ~full;
    assign push   = cl_vld & cl_rdy;
    assign elig   = ~empty & {NUMWRPT{ready & ~wr_bp}};
    assign write  = issue;
    assign idle   = &empty;

    // Lowest-index port wins among eligible heads sharing an address.
    always_comb begin
        issue = '0;
        for (int unsigned i = 0; i < NUMWRPT; i++) begin
            issue[i] = elig[i];
            for (int unsigned j = 0; j < i; j++) begin
                if (elig[j] && (head[j].adr == head[i].adr)) begin
                    issue[i] = 1'b0;
                end
            end
        end
    end

    // Per-port FIFO and flat bus slicing.
    for (genvar g = 0; g < int'(NUMWRPT); g++) begin : g_port
        assign in_beat[g] = {cl_adr[g*BITADDR +: BITADDR], cl_din[g*WIDTH +: WIDTH]};

        algo_wr_fifo u_fifo (
            .clk   (clk),
            .rst   (rst),
            .push  (push[g]),
            .pop   (issue[g]),
            .wdata (in_beat[g]),
            .head  (head[g]),
            .cnt   (cnt[g]),
            .full  (full[g]),
            .empty (empty[g])
        );

        assign wr_adr[g*BITADDR +: BITADDR] = head[g].adr;
        assign din[g*WIDTH +: WIDTH]        = head[g].din;
        assign fifo_cnt[g*BITCNT +: BITCNT] = cnt[g];
    end

endmodule

// File: tb/tb_algo_1r6w_a664_wr_stage.sv
// Bench for the write-ingress stage: queue-based reference model plus directed scenarios.
module tb_algo_1r6w_a664_wr_stage;

    localparam int NP = 6;
    localparam int AW = 13;
    localparam int DW = 32;
    localparam int CW = 3;
    localparam int DEPTH = 4;

    typedef struct {
        logic [AW-1:0] adr;
        logic [DW-1:0] din;
    } beat_t;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic [NP-1:0]     cl_vld = '0;
    logic [NP-1:0]     cl_rdy;
    logic [NP*AW-1:0]  cl_adr = '0;
    logic [NP*DW-1:0]  cl_din = '0;
    logic              ready = 1'b1;
    logic              wr_bp = 1'b0;
    logic [NP-1:0]     write;
    logic [NP*AW-1:0]  wr_adr;
    logic [NP*DW-1:0]  din;
    logic [NP*CW-1:0]  fifo_cnt;
    logic              idle;

    int checks = 0;
    int errors = 0;

    beat_t mq [NP][$];
    bit    run_m = 1'b0;

    algo_1r6w_a664_wr_stage dut (
        .clk      (clk),
        .rst      (rst),
        .cl_vld   (cl_vld),
        .cl_rdy   (cl_rdy),
        .cl_adr   (cl_adr),
        .cl_din   (cl_din),
        .ready    (ready),
        .wr_bp    (wr_bp),
        .write    (write),
        .wr_adr   (wr_adr),
        .din      (din),
        .fifo_cnt (fifo_cnt),
        .idle     (idle)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_beat(input int p, input logic [AW-1:0] a, input logic [DW-1:0] d);
        cl_adr[p*AW +: AW] = a;
        cl_din[p*DW +: DW] = d;
    endtask

    // Monitor / scoreboard: compares DUT against per-port queues each cycle.
    always @(negedge clk) begin : mon
        logic [NP-1:0] exp_rdy;
        logic [NP-1:0] elig;
        logic [NP-1:0] exp_wr;
        logic          all_empty;
        beat_t         b;
        if (!rst) begin
            chk("rst_write", 64'(write), 64'd0);
            chk("rst_rdy", 64'(cl_rdy), 64'd0);
            chk("rst_cnt", 64'(fifo_cnt), 64'd0);
            chk("rst_idle", 64'(idle), 64'd1);
            for (int i = 0; i < NP; i++) mq[i].delete();
            run_m = 1'b0;
        end else begin
            all_empty = 1'b1;
            for (int i = 0; i < NP; i++) begin
                chk($sformatf("cnt%0d", i), 64'(fifo_cnt[i*CW +: CW]), 64'(mq[i].size()));
                exp_rdy[i] = run_m && (mq[i].size() != DEPTH);
                if (mq[i].size() != 0) all_empty = 1'b0;
                elig[i] = (mq[i].size() != 0) && ready && !wr_bp;
            end
            chk("cl_rdy", 64'(cl_rdy), 64'(exp_rdy));
            chk("idle", 64'(idle), 64'(all_empty));
            for (int i = 0; i < NP; i++) begin
                exp_wr[i] = elig[i];
                for (int j = 0; j < i; j++) begin
                    if (elig[j] && mq[j][0].adr == mq[i][0].adr) exp_wr[i] = 1'b0;
                end
            end
            chk("write", 64'(write), 64'(exp_wr));
            for (int i = 0; i < NP; i++) begin
                if (write[i]) begin
                    if (mq[i].size() == 0) begin
                        chk($sformatf("spurious_write%0d", i), 64'd1, 64'd0);
                    end else begin
                        b = mq[i].pop_front();
                        chk($sformatf("wr_adr%0d", i), 64'(wr_adr[i*AW +: AW]), 64'(b.adr));
                        chk($sformatf("din%0d", i), 64'(din[i*DW +: DW]), 64'(b.din));
                    end
                end
            end
            for (int i = 0; i < NP; i++) begin
                if (cl_vld[i] && exp_rdy[i]) begin
                    b.adr = cl_adr[i*AW +: AW];
                    b.din = cl_din[i*DW +: DW];
                    mq[i].push_back(b);
                end
            end
            run_m = 1'b1;
        end
    end

    // Stimulus and directed checks.
    initial begin : drv
        logic [AW-1:0] a0 [4];
        logic [DW-1:0] d0 [4];

        // Reset and release
        repeat (3) cyc();
        chk("rdy_in_reset", 64'(cl_rdy), 64'd0);
        chk("idle_in_reset", 64'(idle), 64'd1);
        rst = 1'b1;
        #1;
        chk("rdy_before_first_clk", 64'(cl_rdy), 64'd0);
        cyc();
        chk("rdy_after_release", 64'(cl_rdy), 64'h3F);

        // Single beat on port 2
        set_beat(2, 13'h005, 32'h0000A5A5);
        cl_vld = 6'b000100;
        cyc();
        cl_vld = '0;
        chk("single_write", 64'(write), 64'b000100);
        chk("single_adr", 64'(wr_adr[2*AW +: AW]), 64'h5);
        chk("single_din", 64'(din[2*DW +: DW]), 64'hA5A5);
        cyc();

        // Fill port 0 under backpressure, then drain in order
        wr_bp = 1'b1;
        for (int k = 0; k < 4; k++) begin
            a0[k] = AW'(k * 7 + 1);
            d0[k] = $urandom;
            set_beat(0, a0[k], d0[k]);
            cl_vld = 6'b000001;
            cyc();
        end
        cl_vld = '0;
        chk("full_rdy0", 64'(cl_rdy[0]), 64'd0);
        chk("full_cnt0", 64'(fifo_cnt[0 +: CW]), 64'd4);
        chk("bp_write", 64'(write), 64'd0);
        wr_bp = 1'b0;
        #1;
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("drain_wr%0d", k), 64'(write), 64'b000001);
            chk($sformatf("drain_adr%0d", k), 64'(wr_adr[0 +: AW]), 64'(a0[k]));
            chk($sformatf("drain_din%0d", k), 64'(din[0 +: DW]), 64'(d0[k]));
            cyc();
        end
        chk("drain_idle", 64'(idle), 64'd1);

        // Same-address conflict on ports 1, 3, 5
        wr_bp = 1'b1;
        set_beat(1, 13'h100, 32'h11111111);
        set_beat(3, 13'h100, 32'h33333333);
        set_beat(5, 13'h100, 32'h55555555);
        cl_vld = 6'b101010;
        cyc();
        cl_vld = '0;
        wr_bp = 1'b0;
        #1;
        chk("conflict_c1", 64'(write), 64'b000010);
        cyc();
        chk("conflict_c2", 64'(write), 64'b001000);
        cyc();
        chk("conflict_c3", 64'(write), 64'b100000);
        cyc();
        chk("conflict_idle", 64'(idle), 64'd1);

        // Port 4 full, then sustained push with pop
        wr_bp = 1'b1;
        cl_vld = 6'b010000;
        for (int k = 0; k < 4; k++) begin
            set_beat(4, AW'($urandom), $urandom);
            cyc();
        end
        wr_bp = 1'b0;
        for (int k = 0; k < 10; k++) begin
            chk($sformatf("sustain_cnt%0d", k), 64'(fifo_cnt[4*CW +: CW]), (k == 0) ? 64'd4 : 64'd3);
            set_beat(4, AW'($urandom), $urandom);
            cyc();
        end
        cl_vld = '0;
        repeat (6) cyc();

        // Macro not ready with traffic on every port
        ready = 1'b0;
        for (int k = 0; k < 20; k++) begin
            for (int p = 0; p < NP; p++) set_beat(p, {3'(p), 10'($urandom)}, $urandom);
            cl_vld = (k == 0) ? 6'h3F : NP'($urandom);
            cyc();
            chk($sformatf("notready_wr%0d", k), 64'(write), 64'd0);
        end
        cl_vld = '0;
        ready = 1'b1;
        #1;
        chk("ready_all_issue", 64'(write), 64'h3F);
        repeat (8) cyc();
        chk("ready_drain_idle", 64'(idle), 64'd1);

        // Randomised traffic with small address set to provoke conflicts
        for (int k = 0; k < 1500; k++) begin
            for (int p = 0; p < NP; p++) set_beat(p, AW'($urandom_range(0, 3)), $urandom);
            cl_vld = NP'($urandom);
            ready = ($urandom % 10) != 0;
            wr_bp = ($urandom % 5) == 0;
            cyc();
        end
        cl_vld = '0;
        ready = 1'b1;
        wr_bp = 1'b0;
        repeat (10) cyc();
        chk("random_idle", 64'(idle), 64'd1);

        // Reset mid-burst with 3 beats queued per port
        wr_bp = 1'b1;
        for (int k = 0; k < 3; k++) begin
            for (int p = 0; p < NP; p++) set_beat(p, {3'(p), 10'(k)}, $urandom);
            cl_vld = 6'h3F;
            cyc();
        end
        cl_vld = '0;
        chk("burst_cnt0", 64'(fifo_cnt[0 +: CW]), 64'd3);
        wr_bp = 1'b0;
        rst = 1'b0;
        #1;
        chk("midrst_write", 64'(write), 64'd0);
        chk("midrst_cnt", 64'(fifo_cnt), 64'd0);
        repeat (2) cyc();
        rst = 1'b1;
        repeat (10) cyc();
        chk("postrst_cnt", 64'(fifo_cnt), 64'd0);
        chk("postrst_idle", 64'(idle), 64'd1);
        chk("postrst_write", 64'(write), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
